// File: rtl/potato_pkg.sv
// Shared types and defaults for the Potato-2 control unit.
// Loop states, instruction encodings and default widths.
package potato_pkg;

    typedef enum logic [1:0] {
        RUN,
        SKIP,
        REVERSE,
        FAULT
    } loop_state_e;

    typedef enum logic [2:0] {
        OP_INC,
        OP_DEC,
        OP_LEFT,
        OP_RIGHT,
        OP_OUT,
        OP_IN,
        OP_OPEN,
        OP_CLOSE
    } op_e;

    localparam int PC_WIDTH_DEF    = 8;
    localparam int STACK_DEPTH_DEF = 4;
    localparam int CTR_WIDTH_DEF   = 16;

    function automatic int depth_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/potato2_loop_unit_if.sv
// Decode/execute-side bundle of the loop unit.
// master: instruction decode + execution controller; slave: loop unit.
interface potato2_loop_unit_if
    import potato_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
);

    localparam int DW = depth_w(STACK_DEPTH);

    logic                Step;
    logic                Open;
    logic                Close;
    logic                ZeroFlag;
    logic [PC_WIDTH-1:0] Pc;
    logic                SkipCmd;
    logic                Reverse;
    logic [DW-1:0]       Depth;
    logic                Fault;

    modport master (
        output Step, Open, Close, ZeroFlag,
        input  Pc, SkipCmd, Reverse, Depth, Fault
    );

    modport slave (
        input  Step, Open, Close, ZeroFlag,
        output Pc, SkipCmd, Reverse, Depth, Fault
    );

endinterface

// File: rtl/loop_stack.sv
// Return-address LIFO for taken loops.
// Reset clears the count only; entries are don't-care.
module loop_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [2**IW];
    logic [CW-1:0]    count_q;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;

    assign wr_idx = count_q[IW-1:0];
    assign rd_idx = wr_idx - IW'(1);
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign top    = mem[rd_idx];

    always_ff @(posedge Clock) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + CW'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/potato2_loop_unit.sv
// Potato-2 loop/PC unit: stack-first `]` jumps with
// bracket-scan fallback once loops spill past the stack.
module potato2_loop_unit
    import potato_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int CTR_WIDTH   = CTR_WIDTH_DEF
) (
    input  logic                Clock,
    input  logic                Reset_n,
    potato2_loop_unit_if.slave  bus
);

    localparam int DW = depth_w(STACK_DEPTH);

    loop_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [PC_WIDTH-1:0]  pc_inc, pc_dec;
    logic [PC_WIDTH-1:0]  top;
    logic [CTR_WIDTH-1:0] ctr_q, ctr_d;
    logic [CTR_WIDTH-1:0] spill_q, spill_d;
    logic                 push, pop;
    logic                 full, empty;
    logic [DW-1:0]        count;
    logic                 trap;
    logic                 ctr_max, spill_max;

    loop_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (top),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign pc_inc    = pc_q + PC_WIDTH'(1);
    assign pc_dec    = pc_q - PC_WIDTH'(1);
    assign ctr_max   = (ctr_q == '1);
    assign spill_max = (spill_q == '1);

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= RUN;
            pc_q    <= '0;
            ctr_q   <= '0;
            spill_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ctr_q   <= ctr_d;
            spill_q <= spill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ctr_d   = ctr_q;
        spill_d = spill_q;
        push    = 1'b0;
        pop     = 1'b0;
        trap    = 1'b0;
        if (bus.Step && state_q != FAULT) begin
            if (bus.Open && bus.Close) begin
                trap = 1'b1;
            end else begin
                unique case (state_q)
                    RUN: begin
                        unique case (1'b1)
                            bus.Open: begin
                                pc_d = pc_inc;
                                if (bus.ZeroFlag) begin
                                    ctr_d   = CTR_WIDTH'(1);
                                    state_d = SKIP;
                                end else if (!full) begin
                                    push = 1'b1;
                                end else if (spill_max) begin
                                    trap = 1'b1;
                                end else begin
                                    spill_d = spill_q + CTR_WIDTH'(1);
                                end
                            end
                            bus.Close: begin
                                // spilled loops are innermost: check spill first
                                if (bus.ZeroFlag) begin
                                    pc_d = pc_inc;
                                    if (spill_q != '0) begin
                                        spill_d = spill_q - CTR_WIDTH'(1);
                                    end else if (!empty) begin
                                        pop = 1'b1;
                                    end else begin
                                        trap = 1'b1;
                                    end
                                end else if (spill_q != '0) begin
                                    ctr_d   = CTR_WIDTH'(1);
                                    state_d = REVERSE;
                                    pc_d    = pc_dec;
                                end else if (!empty) begin
                                    pc_d = top;
                                end else begin
                                    trap = 1'b1;
                                end
                            end
                            default: pc_d = pc_inc;
                        endcase
                    end
                    SKIP: begin
                        pc_d = pc_inc;
                        unique case (1'b1)
                            bus.Open: begin
                                if (ctr_max) begin
                                    trap = 1'b1;
                                end else begin
                                    ctr_d = ctr_q + CTR_WIDTH'(1);
                                end
                            end
                            bus.Close: begin
                                ctr_d = ctr_q - CTR_WIDTH'(1);
                                if (ctr_q == CTR_WIDTH'(1)) begin
                                    state_d = RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                    REVERSE: begin
                        pc_d = pc_dec;
                        unique case (1'b1)
                            bus.Close: begin
                                if (ctr_max) begin
                                    trap = 1'b1;
                                end else begin
                                    ctr_d = ctr_q + CTR_WIDTH'(1);
                                end
                            end
                            bus.Open: begin
                                ctr_d = ctr_q - CTR_WIDTH'(1);
                                if (ctr_q == CTR_WIDTH'(1)) begin
                                    state_d = RUN;
                                    pc_d    = pc_inc;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
        // a fault freezes everything at its pre-step value
        if (trap) begin
            state_d = FAULT;
            pc_d    = pc_q;
            ctr_d   = ctr_q;
            spill_d = spill_q;
            push    = 1'b0;
            pop     = 1'b0;
        end
    end

    assign bus.Pc      = pc_q;
    assign bus.SkipCmd = (state_q == SKIP) || (state_q == REVERSE);
    assign bus.Reverse = (state_q == REVERSE);
    assign bus.Depth   = count;
    assign bus.Fault   = (state_q == FAULT);

endmodule

// File: tb/tb_potato2_loop_unit.sv
// Directed bench for potato2_loop_unit: a default instance
// plus a 4-bit-PC, single-entry-stack instance.
module tb_potato2_loop_unit;
    import potato_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    potato2_loop_unit_if #(.PC_WIDTH(8), .STACK_DEPTH(4)) ia ();
    potato2_loop_unit_if #(.PC_WIDTH(4), .STACK_DEPTH(1)) ib ();

    potato2_loop_unit #(
        .PC_WIDTH(8), .STACK_DEPTH(4), .CTR_WIDTH(16)
    ) dut_a (
        .Clock(clk), .Reset_n(rst_n), .bus(ia)
    );

    potato2_loop_unit #(
        .PC_WIDTH(4), .STACK_DEPTH(1), .CTR_WIDTH(16)
    ) dut_b (
        .Clock(clk), .Reset_n(rst_n), .bus(ib)
    );

    task automatic chk(input string t,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", t, obs, exp);
        end
    endtask

    task automatic ca(input string t, input int pc,
                      input bit sk, input bit rv,
                      input int d, input bit f);
        chk({t, ".pc"},    32'(ia.Pc),      pc);
        chk({t, ".skip"},  32'(ia.SkipCmd), 32'(sk));
        chk({t, ".rev"},   32'(ia.Reverse), 32'(rv));
        chk({t, ".depth"}, 32'(ia.Depth),   d);
        chk({t, ".fault"}, 32'(ia.Fault),   32'(f));
    endtask

    task automatic cb(input string t, input int pc,
                      input bit sk, input bit rv,
                      input int d, input bit f);
        chk({t, ".pc"},    32'(ib.Pc),      pc);
        chk({t, ".skip"},  32'(ib.SkipCmd), 32'(sk));
        chk({t, ".rev"},   32'(ib.Reverse), 32'(rv));
        chk({t, ".depth"}, 32'(ib.Depth),   d);
        chk({t, ".fault"}, 32'(ib.Fault),   32'(f));
    endtask

    task automatic sa(input logic s, input logic o,
                      input logic c, input logic z);
        @(negedge clk);
        rst_n       = 1'b1;
        ia.Step     = s;
        ia.Open     = o;
        ia.Close    = c;
        ia.ZeroFlag = z;
        ib.Step     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic sb(input logic s, input logic o,
                      input logic c, input logic z);
        @(negedge clk);
        rst_n       = 1'b1;
        ib.Step     = s;
        ib.Open     = o;
        ib.Close    = c;
        ib.ZeroFlag = z;
        ia.Step     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rst();
        @(negedge clk);
        rst_n   = 1'b0;
        ia.Step = 1'b0;
        ib.Step = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ia.Step = 0; ia.Open = 0; ia.Close = 0; ia.ZeroFlag = 0;
        ib.Step = 0; ib.Open = 0; ib.Close = 0; ib.ZeroFlag = 0;
        rst();
        rst();
        ca("rst", 0, 0, 0, 0, 0);

        // [[-]-] : inner taken once, outer taken once
        sa(1, 1, 0, 0); ca("n0", 1, 0, 0, 1, 0);
        sa(1, 1, 0, 0); ca("n1", 2, 0, 0, 2, 0);
        sa(1, 0, 0, 0); ca("n2", 3, 0, 0, 2, 0);
        sa(1, 0, 1, 0); ca("n3", 2, 0, 0, 2, 0);
        sa(1, 0, 0, 0); ca("n4", 3, 0, 0, 2, 0);
        sa(1, 0, 1, 1); ca("n5", 4, 0, 0, 1, 0);
        sa(1, 0, 0, 0); ca("n6", 5, 0, 0, 1, 0);
        sa(1, 0, 1, 0); ca("n7", 1, 0, 0, 1, 0);
        sa(1, 1, 0, 0); ca("n8", 2, 0, 0, 2, 0);
        sa(1, 0, 0, 0); ca("n9", 3, 0, 0, 2, 0);
        sa(1, 0, 1, 1); ca("n10", 4, 0, 0, 1, 0);
        sa(1, 0, 0, 0); ca("n11", 5, 0, 0, 1, 0);
        sa(1, 0, 1, 1); ca("n12", 6, 0, 0, 0, 0);

        // forward skip from [ at 3 over [ ] ]
        rst();
        ca("rst2", 0, 0, 0, 0, 0);
        repeat (3) sa(1, 0, 0, 0);
        ca("s0", 3, 0, 0, 0, 0);
        sa(1, 1, 0, 1); ca("s1", 4, 1, 0, 0, 0);
        sa(1, 1, 0, 0); ca("s2", 5, 1, 0, 0, 0);
        repeat (10) sa(0, 0, 1, 0);
        ca("gate", 5, 1, 0, 0, 0);
        sa(1, 0, 1, 0); ca("s3", 6, 1, 0, 0, 0);
        sa(1, 0, 1, 0); ca("s4", 7, 0, 0, 0, 0);
        sa(1, 0, 0, 0); ca("s5", 8, 0, 0, 0, 0);

        // faults
        rst();
        repeat (5) sa(1, 0, 0, 0);
        ca("f0", 5, 0, 0, 0, 0);
        sa(1, 0, 1, 0); ca("f1", 5, 0, 0, 0, 1);
        repeat (3) sa(1, 0, 0, 0);
        sa(1, 1, 0, 0); ca("f2", 5, 0, 0, 0, 1);
        rst();
        ca("f3", 0, 0, 0, 0, 0);
        sa(1, 0, 0, 0);
        sa(1, 1, 1, 0); ca("f4", 1, 0, 0, 0, 1);
        rst();

        // single-entry stack: three nested taken loops
        cb("b_rst", 0, 0, 0, 0, 0);
        sb(1, 1, 0, 0); cb("b0", 1, 0, 0, 1, 0);
        sb(1, 1, 0, 0); cb("b1", 2, 0, 0, 1, 0);
        sb(1, 1, 0, 0); cb("b2", 3, 0, 0, 1, 0);
        sb(1, 0, 0, 0); cb("b3", 4, 0, 0, 1, 0);
        sb(1, 0, 1, 0); cb("b4", 3, 1, 1, 1, 0);
        sb(1, 0, 0, 0); cb("b5", 2, 1, 1, 1, 0);
        sb(1, 1, 0, 0); cb("b6", 3, 0, 0, 1, 0);
        sb(1, 0, 0, 0); cb("b7", 4, 0, 0, 1, 0);
        sb(1, 0, 1, 1); cb("b8", 5, 0, 0, 1, 0);
        sb(1, 0, 1, 1); cb("b9", 6, 0, 0, 1, 0);
        sb(1, 0, 1, 0); cb("b10", 1, 0, 0, 1, 0);
        sb(1, 1, 0, 0); cb("b11", 2, 0, 0, 1, 0);
        sb(1, 0, 0, 0); cb("b12", 3, 0, 0, 1, 0);
        sb(1, 0, 1, 0); cb("b13", 2, 1, 1, 1, 0);

        // reset mid-reverse
        rst();
        cb("b_rr", 0, 0, 0, 0, 0);

        // 4-bit pc wrap
        repeat (15) sb(1, 0, 0, 0);
        cb("w0", 15, 0, 0, 0, 0);
        sb(1, 0, 0, 0); cb("w1", 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/potato2_loop_unit.md
# potato2_loop_unit

Loop/program-counter unit for the Potato-2 control unit, succeeding the Potato-1 reverse-scan loop control. It owns the program counter and resolves `[`/`]` control flow. Taken backward jumps go directly through a parametrised return-address stack. When the stack is exhausted, it falls back to forward/backward bracket scanning with a wide nesting counter. It sits between instruction decode (which supplies `Open`, `Close` and `Step`) and the execution controller (which consumes `SkipCmd`).

## Interface
- `PC_WIDTH`, 8: program counter width; instruction memory depth is 2^PC_WIDTH.
- `STACK_DEPTH`, 4: return-address stack entries, ≥1.
- `CTR_WIDTH`, 16: width of the nesting/scan counter and the spill counter.

- `Clock` in 1: single clock; all state updates on the rising edge.
- `Reset_n` in 1: reset, synchronous and active-low.
- `Step` in 1: current instruction is valid and retires this cycle (low while waiting on IO).
- `Open` in 1: current instruction is `[`.
- `Close` in 1: current instruction is `]`.
- `ZeroFlag` in 1: current data cell equals zero; sampled only with `Step`.
- `Pc` out PC_WIDTH: address of the current instruction.
- `SkipCmd` out 1: current instruction is suppressed (state SKIP or REVERSE).
- `Reverse` out 1: backward scan in progress.
- `Depth` out clog2(STACK_DEPTH+1): occupied stack entries.
- `Fault` out 1: sticky; control-flow error detected, unit halted.

## Operation
- States: RUN, SKIP, REVERSE, FAULT. All actions below occur only on a cycle with `Step`=1; otherwise all state holds.
- `Open`&`Close` both high with `Step` → FAULT.
- RUN:
  - `[`, ZeroFlag=0: enter loop. If the stack is not full, push Pc+1; otherwise increment spill. Pc+1.
  - `[`, ZeroFlag=1: ctr←1, go SKIP, Pc+1.
  - `]`, ZeroFlag=0:
    - spill>0 → ctr←1, go REVERSE, Pc−1.
    - else stack non-empty → Pc←top; stack unchanged.
    - else → FAULT.
  - `]`, ZeroFlag=1:
    - spill>0 → decrement spill.
    - else stack non-empty → pop.
    - else → FAULT.
    - In every non-FAULT case, Pc+1.
  - Other instructions: Pc+1.
- SKIP: Pc+1 every step.
  - `[` → ctr+1.
  - `]` → ctr−1; when ctr reaches 0, go RUN.
- REVERSE: every step moves Pc−1, except the terminating `[` step.
  - `]` → ctr+1.
  - `[` → ctr−1; when ctr reaches 0, go RUN with Pc+1 (the loop body start).
  - Spill is unchanged, because the loop is still active.
- Overflow and wrap:
  - Push with spill at its maximum, or ctr increment at its maximum → FAULT.
  - Pc arithmetic wraps modulo 2^PC_WIDTH; wrap is legal, not a fault.
- FAULT: all state frozen, `Step` ignored; exits only via reset.
- Spilled loops are always the innermost ones, so spill is checked before the stack on `]`.

## Timing
- All outputs are registered and update the cycle after the qualifying `Step`. There is no combinational path from inputs to outputs.
- Reset values: Pc=0, state RUN, SkipCmd=0, Reverse=0, Depth=0, spill=0, ctr=0, Fault=0. Stack contents are don't-care.
- Reset asserted mid-scan or mid-fault fully restores the reset values at the next edge.
- Taken `]` with a stack hit: Pc=top one cycle after `Step`, with zero scan cycles.
- A scan costs one `Step` per instruction traversed.
- SkipCmd=Reverse=1 throughout REVERSE. SkipCmd=1, Reverse=0 throughout SKIP.
- The `[` or `]` that starts a scan is itself a control instruction with no datapath effect; it is not suppressed.

## Structure
- Shared package `potato_pkg`:
  - loop state enum {RUN, SKIP, REVERSE, FAULT};
  - instruction encodings;
  - default widths for PC_WIDTH, STACK_DEPTH and CTR_WIDTH.
- Sub-module `loop_stack`: parametrised LIFO with push, pop, top, full, empty and count.
  - Push and pop in the same cycle are never issued.
  - Reset clears count only.
- The top level holds the FSM, Pc, ctr and spill.

## Test plan
- Nested loops within stack capacity: STACK_DEPTH=4, program `[[-]-]` with cell=2, inner cell=1 → every taken `]` loads Pc=top in 1 cycle; Reverse is never 1; Depth peaks at 2.
- Stack overflow fallback: STACK_DEPTH=1, three nested taken `[` → Depth=1, spill=2. Innermost taken `]` → Reverse=1 until the matching `[`, then Pc=that `[`+1. Outermost `]` jumps directly.
- Forward skip: `[` at Pc=3 with ZeroFlag=1 over `[ ] ]` body → SkipCmd=1 for Pc 4..6; RUN resumes with Pc=7.
- Fault cases:
  - `]` at Pc=5 with empty stack and ZeroFlag=0 → Fault=1 next cycle; Pc stays 5 under further `Step`.
  - `Open`=`Close`=1 → Fault=1.
- Step gating: hold `Step`=0 for 10 cycles mid-SKIP → Pc, ctr and SkipCmd are unchanged.
- Reset during REVERSE: Reset_n=0 for 1 cycle → Pc=0, Reverse=0, SkipCmd=0, Depth=0, Fault=0.
- Pc wrap: PC_WIDTH=4, Pc=15 with a plain instruction → Pc=0, no fault.
